// File: rtl/fsm_tx_pkg.sv
// Shared encodings for the framed symbol transmitter and the recognizers that consume its stream.
package fsm_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC1 = 3'd1,
        SYNC2 = 3'd2,
        DATA  = 3'd3,
        PAR   = 3'd4
    } state_e;

    localparam logic [1:0] SYNC_A = 2'b11;
    localparam logic [1:0] SYNC_B = 2'b00;

    // Symbol counter must hold W/2-1; a W=2 build still needs one bit.
    function automatic int cnt_width(input int w);
        int cw;
        cw = $clog2(w / 2);
        return (cw < 1) ? 1 : cw;
    endfunction

endpackage

// File: rtl/fsm_tx_registro_r.sv
// Generic enabled register with asynchronous active-low clear to zero.
module registro_r #(
    parameter int N = 1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    // Storage element: clears on reset, loads d when enabled.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fsm_tx.sv
// Moore transmitter: sync pair, W/2 data symbols MSB-first, then a parity symbol.
// Outputs are registered from the next-state values so they still track the current state.
module fsm_tx
    import fsm_tx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset_n,
    output logic [1:0]   x,
    output logic         valid,
    output logic         busy,
    input  logic [W-1:0] data,
    input  logic         start
);

    localparam int            CW   = cnt_width(W);
    localparam logic [CW-1:0] LAST = CW'(W / 2 - 1);

    logic [2:0]    state_bits_q;
    state_e        state_q;
    state_e        state_d;
    logic [W-1:0]  shift_q;
    logic [W-1:0]  shift_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          par_q;
    logic          par_d;
    logic [3:0]    out_q;
    logic [3:0]    out_d;

    assign state_q = state_e'(state_bits_q);

    registro_r #(.N(3))  u_state (.clock(clock), .reset_n(reset_n), .en(1'b1), .d(state_d), .q(state_bits_q));
    registro_r #(.N(W))  u_shift (.clock(clock), .reset_n(reset_n), .en(1'b1), .d(shift_d), .q(shift_q));
    registro_r #(.N(CW)) u_cnt   (.clock(clock), .reset_n(reset_n), .en(1'b1), .d(cnt_d),   .q(cnt_q));
    registro_r #(.N(1))  u_par   (.clock(clock), .reset_n(reset_n), .en(1'b1), .d(par_d),   .q(par_q));
    registro_r #(.N(4))  u_out   (.clock(clock), .reset_n(reset_n), .en(1'b1), .d(out_d),   .q(out_q));

    // Next-state network: capture on start, then walk the frame; start is ignored once busy.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SYNC1;
                    shift_d = data;
                    cnt_d   = '0;
                    par_d   = ^data;
                end else begin
                    state_d = IDLE;
                end
            end
            SYNC1: state_d = SYNC2;
            SYNC2: state_d = DATA;
            DATA: begin
                shift_d = shift_q << 2;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = PAR;
                end else begin
                    state_d = DATA;
                end
            end
            PAR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output network, evaluated on next-state values: {busy, valid, x}.
    always_comb begin
        out_d = 4'b0000;
        case (state_d)
            IDLE:    out_d = 4'b0000;
            SYNC1:   out_d = {2'b11, SYNC_A};
            SYNC2:   out_d = {2'b11, SYNC_B};
            DATA:    out_d = {2'b11, shift_d[W-1 -: 2]};
            PAR:     out_d = {2'b11, 1'b0, par_d};
            default: out_d = 4'b0000;
        endcase
    end

    assign busy  = out_q[3];
    assign valid = out_q[2];
    assign x     = out_q[1:0];

endmodule

// File: tb/tb_fsm_tx.sv
// Directed bench: expected {busy,valid,x} per cycle queued at stimulus time, popped after each edge.
module tb_fsm_tx;

    logic       clock;
    logic       reset_n;
    logic [1:0] x;
    logic       valid;
    logic       busy;
    logic [7:0] data;
    logic       start;

    logic [1:0] x2;
    logic       valid2;
    logic       busy2;
    logic [1:0] data2;
    logic       start2;

    int total;
    int bad;
    logic [3:0] exp_q[$];
    logic       last_busy;

    fsm_tx #(.W(8)) dut (
        .clock(clock), .reset_n(reset_n), .x(x), .valid(valid), .busy(busy),
        .data(data), .start(start)
    );

    fsm_tx #(.W(2)) dut2 (
        .clock(clock), .reset_n(reset_n), .x(x2), .valid(valid2), .busy(busy2),
        .data(data2), .start(start2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [7:0] d);
        logic p;
        exp_q.push_back({2'b11, 2'b11});
        exp_q.push_back({2'b11, 2'b00});
        for (int i = 0; i < 4; i++) exp_q.push_back({2'b11, d[7-2*i -: 2]});
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ d[i];
        exp_q.push_back({2'b11, 1'b0, p});
    endtask

    task automatic tick(input string tag, input logic st, input logic [7:0] d);
        logic [3:0] e;
        start = st;
        data  = d;
        if (st && !last_busy) push_frame(d);
        @(posedge clock);
        #1;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 4'b0000;
        last_busy = e[3];
        check(tag, {busy, valid, x}, e);
    endtask

    initial begin
        logic [3:0] w2_exp [0:4];
        total = 0;
        bad = 0;
        last_busy = 1'b0;
        reset_n = 1'b0;
        start = 1'b0;
        data = 8'h00;
        start2 = 1'b0;
        data2 = 2'b00;
        #12;
        check("reset", {busy, valid, x}, 4'b0000);
        check("reset_w2", {busy2, valid2, x2}, 4'b0000);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) tick("idle", 1'b0, 8'hA5);

        tick("b4", 1'b1, 8'hB4);
        for (int i = 0; i < 8; i++) tick("b4", 1'b0, 8'h00);

        for (int i = 0; i < 20; i++) tick("held", 1'b1, 8'h01);
        for (int i = 0; i < 10; i++) tick("drain", 1'b0, 8'h00);

        tick("latch", 1'b1, 8'hFF);
        for (int i = 0; i < 8; i++) tick("latch", 1'b0, 8'h00);

        // Abort mid-frame during the third data symbol.
        tick("abort", 1'b1, 8'hB4);
        for (int i = 0; i < 4; i++) tick("abort", 1'b0, 8'h00);
        reset_n = 1'b0;
        #1;
        check("async_rst", {busy, valid, x}, 4'b0000);
        exp_q.delete();
        last_busy = 1'b0;
        @(negedge clock);
        check("rst_hold", {busy, valid, x}, 4'b0000);
        reset_n = 1'b1;
        tick("restart", 1'b1, 8'h01);
        for (int i = 0; i < 8; i++) tick("restart", 1'b0, 8'h00);

        w2_exp[0] = 4'b1111;
        w2_exp[1] = 4'b1100;
        w2_exp[2] = 4'b1110;
        w2_exp[3] = 4'b1101;
        w2_exp[4] = 4'b0000;
        start2 = 1'b1;
        data2 = 2'b10;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock);
            #1;
            start2 = 1'b0;
            data2 = 2'b00;
            check("w2", {busy2, valid2, x2}, w2_exp[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fsm_tx.md
# fsm_tx

Moore transmitter that produces the 2-bit symbol stream consumed by the team's Mealy symbol recognizers. It captures a W-bit word on a start request and emits a framed burst: two sync symbols, W/2 data symbols MSB-first, and one parity symbol, one symbol per clock. It is built from a registered state, a next-state network and an output network.

## Interface

Parameters:
- W, 8, data word width; must be even and ≥ 2.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- x  output  2  current symbol; 2'b00 when not valid.
- valid  output  1  high while x carries a frame symbol.
- busy  output  1  high while a frame is in progress (state ≠ IDLE).
- data  input  W  word to transmit; sampled only when a start is accepted.
- start  input  1  transmit request.

## Operation

- States: IDLE, SYNC1, SYNC2, DATA, PAR.
- IDLE: outputs x=2'b00, valid=0, busy=0. If start=1, latch data into the shift register, clear the symbol counter and go to SYNC1; otherwise stay in IDLE.
- SYNC1: outputs x=2'b11, valid=1. Next state is SYNC2.
- SYNC2: outputs x=2'b00, valid=1. Next state is DATA.
- DATA: x = top two bits of the shift register, valid=1.
  - Each cycle, shift left by 2 and increment the counter.
  - After the W/2-th data symbol, go to PAR.
- PAR: outputs x={1'b0, ^latched_word}, valid=1. Next state is IDLE.
- Parity is computed on the word latched at start, not on the live data input. Store it at capture.
- start is ignored whenever busy=1. No queuing.
- data may change freely after the capture cycle.
- Outputs are a function of state and registers only (Moore). There is no combinational path from start or data to x, valid or busy.
- Counter width is $clog2(W/2), minimum 1. With W=2 there is exactly one DATA cycle.

## Timing

- Reset (reset_n=0, at any time including mid-frame):
  - Forces IDLE immediately and asynchronously.
  - x=2'b00, valid=0, busy=0.
  - Shift register, counter and parity register are all cleared.
  - The interrupted frame is abandoned and never resumed.
- Latency: start accepted at edge k puts SYNC1 on x during cycle k+1.
- Frame length is W/2+3 valid cycles. For W=8 that is 7.
- The first IDLE cycle follows PAR, so back-to-back frames have a gap of one cycle with valid=0.
- With start held high continuously, a new frame begins every W/2+4 cycles.
- start asserted in the PAR cycle is ignored, because busy=1 in that cycle.
- Release of reset_n is synchronous in effect: the first transition out of IDLE happens at the first rising edge with reset_n=1 and start=1.

## Structure

- Shared package fsm_tx_pkg holds:
  - state encoding constants: IDLE=3'd0, SYNC1=3'd1, SYNC2=3'd2, DATA=3'd3, PAR=3'd4;
  - sync symbols SYNC_A=2'b11 and SYNC_B=2'b00.
  - Recognizer blocks import the same constants.
- Sub-module registro_r: parameterized register with enable and asynchronous active-low reset to zero.
  - Used for the state, shift, counter and parity registers.
- Next-state logic and output logic are separate combinational networks, matching the state register / next-state / output split used elsewhere.

## Test plan

- Reset, then hold start=0 for 5 cycles -> x=2'b00, valid=0 and busy=0 throughout.
- W=8, data=8'hB4, 1-cycle start pulse -> valid for 7 cycles with x = 11,00,10,11,01,00,00; busy low again the cycle after PAR.
- data=8'h01, start held high for 20 cycles -> repeated frames 11,00,00,00,00,01,01, each separated by exactly one valid=0 cycle.
- Start 8'hFF, change data to 8'h00 the cycle after capture -> frame is 11,00,11,11,11,11,00, proving data and parity are latched.
- Pull reset_n low during the third DATA symbol -> outputs go to zero immediately without waiting for an edge; after release with start=1 and data=8'h01, a fresh frame runs from SYNC1.
- W=2 build, data=2'b10 -> frame is 11,00,10,01.
